rtc_bus_sequencer: RTL and testbench

Sequences every access on the multiplexed address/data bus of the external RTC (a_d, cs, rd, wr, AD). It arbitrates round-robin between two requesters: port 0 is the programming/configuration writer and port 1 is the periodic register-refresh reader. For each granted request it generates a registered, glitch-free address-phase/data-phase waveform with programmable phase lengths. On reads it captures the returned byte and hands it back with a one-cycle acknowledge.

---
 rtl/rtc_bus_sequencer.sv | 159 +++++++++++++++
 tb/tb_rtc_bus_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_bus_sequencer.sv
// Bus sequencer for an external RTC with a multiplexed address/data bus.
// Round-robin arbitration between two requesters, registered address/data phase waveforms.
module rtc_bus_sequencer #(
    parameter int T_ACT = 10,
    parameter int T_GAP = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       we0,
    input  logic [7:0] addr0,
    input  logic [7:0] wdata0,
    input  logic       req1,
    input  logic       we1,
    input  logic [7:0] addr1,
    input  logic [7:0] wdata1,
    output logic       ack0,
    output logic       ack1,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       a_d,
    output logic       cs,
    output logic       rd,
    output logic       wr,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    input  logic [7:0] ad_in
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ADDR = 3'd1;
    localparam logic [2:0] S_GAP1 = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_GAP2 = 3'd4;

    localparam logic [7:0] ACT_LAST = 8'(T_ACT - 1);
    localparam logic [7:0] GAP_LAST = 8'(T_GAP - 1);

    logic [2:0] state, state_nx;
    logic [7:0] cnt, cnt_nx;
    logic       last_grant, last_grant_nx;
    logic       cur_port, port_nx;
    logic       cur_we, we_nx;
    logic [7:0] cur_addr, addr_nx;
    logic [7:0] cur_wdata, wdata_nx;
    logic       gnt;

    // Next-state, counter and transaction latch.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt + 8'd1;
        last_grant_nx = last_grant;
        port_nx       = cur_port;
        we_nx         = cur_we;
        addr_nx       = cur_addr;
        wdata_nx      = cur_wdata;
        gnt           = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_nx = 8'd0;
                if (req0 || req1) begin
                    gnt           = (req0 && req1) ? ~last_grant : req1;
                    state_nx      = S_ADDR;
                    last_grant_nx = gnt;
                    port_nx       = gnt;
                    we_nx         = gnt ? we1    : we0;
                    addr_nx       = gnt ? addr1  : addr0;
                    wdata_nx      = gnt ? wdata1 : wdata0;
                end
            end
            S_ADDR: if (cnt == ACT_LAST) begin state_nx = S_GAP1; cnt_nx = 8'd0; end
            S_GAP1: if (cnt == GAP_LAST) begin state_nx = S_DATA; cnt_nx = 8'd0; end
            S_DATA: if (cnt == ACT_LAST) begin state_nx = S_GAP2; cnt_nx = 8'd0; end
            S_GAP2: if (cnt == GAP_LAST) begin state_nx = S_IDLE; cnt_nx = 8'd0; end
            default: begin
                state_nx = S_IDLE;
                cnt_nx   = 8'd0;
            end
        endcase
    end

    // NOTE: all state and outputs use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            cnt        <= 8'd0;
            last_grant <= 1'b1;
            cur_port   <= 1'b0;
            cur_we     <= 1'b0;
            cur_addr   <= 8'd0;
            cur_wdata  <= 8'd0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            last_grant <= last_grant_nx;
            cur_port   <= port_nx;
            cur_we     <= we_nx;
            cur_addr   <= addr_nx;
            cur_wdata  <= wdata_nx;
        end
    end

    // Outputs are decoded from the state being entered, so they switch on the entry edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_d    <= 1'b1;
            cs     <= 1'b1;
            rd     <= 1'b1;
            wr     <= 1'b1;
            ad_oe  <= 1'b0;
            ad_out <= 8'd0;
            ack0   <= 1'b0;
            ack1   <= 1'b0;
            busy   <= 1'b0;
            rdata  <= 8'd0;
        end else begin
            a_d   <= 1'b1;
            cs    <= 1'b1;
            rd    <= 1'b1;
            wr    <= 1'b1;
            ad_oe <= 1'b0;
            ack0  <= 1'b0;
            ack1  <= 1'b0;
            busy  <= (state_nx != S_IDLE);
            case (state_nx)
                S_ADDR: begin
                    a_d    <= 1'b0;
                    cs     <= 1'b0;
                    ad_oe  <= 1'b1;
                    ad_out <= addr_nx;
                    wr     <= ~we_nx;
                    rd     <= we_nx;
                end
                S_DATA: begin
                    cs <= 1'b0;
                    if (we_nx) begin
                        wr     <= 1'b0;
                        ad_oe  <= 1'b1;
                        ad_out <= wdata_nx;
                    end else begin
                        rd <= 1'b0;
                    end
                end
                S_GAP2: begin
                    if (cnt_nx == GAP_LAST) begin
                        ack0 <= ~port_nx;
                        ack1 <= port_nx;
                    end
                end
                default: ;
            endcase
            // Read byte is captured on the edge that leaves the last DATA cycle.
            if (state == S_DATA && cnt == ACT_LAST && !cur_we)
                rdata <= ad_in;
        end
    end

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Self-checking bench for rtc_bus_sequencer: an offset-based transaction model checked
// every cycle, plus directed scenarios with hand-computed literal expectations.
module tb_rtc_bus_sequencer;

    localparam int TA = 4;
    localparam int TG = 2;
    localparam int L  = 2 * TA + 2 * TG;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [7:0] addr0 = 8'd0, wdata0 = 8'd0, addr1 = 8'd0, wdata1 = 8'd0;
    logic [7:0] ad_in = 8'd0;
    logic       ack0, ack1, busy, a_d, cs, rd, wr, ad_oe;
    logic [7:0] rdata, ad_out;

    int checks   = 0;
    int failures = 0;

    rtc_bus_sequencer #(.T_ACT(TA), .T_GAP(TG)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
        .a_d(a_d), .cs(cs), .rd(rd), .wr(wr),
        .ad_out(ad_out), .ad_oe(ad_oe), .ad_in(ad_in)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        check(name, 16'(act), 16'(exp));
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_ack(input bit port, output int n);
        n = 0;
        while (!(port ? ack1 : ack0) && n < 200) begin
            tick();
            n++;
        end
    endtask

    // Model: a transaction is a window of L cycles indexed by offset m_k from its first ADDR cycle.
    bit         m_active = 1'b0;
    int         m_k      = 0;
    bit         m_lg     = 1'b1;
    bit         m_port   = 1'b0;
    bit         m_we     = 1'b0;
    logic [7:0] m_addr   = 8'd0;
    logic [7:0] m_wdata  = 8'd0;
    logic [7:0] m_rdata  = 8'd0;
    logic [7:0] m_adout  = 8'd0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_active = 1'b0;
            m_k      = 0;
            m_lg     = 1'b1;
            m_rdata  = 8'd0;
            m_adout  = 8'd0;
        end else if (m_active) begin
            if (m_k == 2 * TA + TG - 1 && !m_we) m_rdata = ad_in;
            if (m_k == L - 1) begin
                m_active = 1'b0;
            end else begin
                m_k++;
                if (m_k == TA + TG && m_we) m_adout = m_wdata;
            end
        end else if (req0 || req1) begin
            m_port   = (req0 && req1) ? !m_lg : req1;
            m_we     = m_port ? we1 : we0;
            m_addr   = m_port ? addr1 : addr0;
            m_wdata  = m_port ? wdata1 : wdata0;
            m_lg     = m_port;
            m_active = 1'b1;
            m_k      = 0;
            m_adout  = m_addr;
        end
    end

    always @(negedge clk) begin
        bit pa, pd, fin;
        logic [7:0] exp_bus, act_bus;
        pa  = m_active && (m_k < TA);
        pd  = m_active && (m_k >= TA + TG) && (m_k < 2 * TA + TG);
        fin = m_active && (m_k == L - 1);
        exp_bus = {m_active, !pa, !(pa || pd), !((pa || pd) && !m_we),
                   !((pa || pd) && m_we), pa || (pd && m_we),
                   fin && !m_port, fin && m_port};
        act_bus = {busy, a_d, cs, rd, wr, ad_oe, ack0, ack1};
        check("bus {busy,a_d,cs,rd,wr,oe,ack0,ack1}", 16'(act_bus), 16'(exp_bus));
        check("ad_out", 16'(ad_out), 16'(m_adout));
        check("rdata", 16'(rdata), 16'(m_rdata));
    end

    initial begin
        int n, k, busy_low;
        #1 rst = 1'b0;
        tick();
        chk1("reset a_d", a_d, 1'b1);
        chk1("reset cs", cs, 1'b1);
        chk1("reset ad_oe", ad_oe, 1'b0);
        check("reset rdata", 16'(rdata), 16'h0000);
        tick();
        rst = 1'b1;
        tick();

        // Write on port 0, with the request fields changed right after grant.
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h21; wdata0 = 8'h45;
        tick();
        chk1("t1 a_d", a_d, 1'b0);
        chk1("t1 wr", wr, 1'b0);
        chk1("t1 rd", rd, 1'b1);
        check("t1 addr", 16'(ad_out), 16'h0021);
        addr0 = 8'hAA; wdata0 = 8'hBB;
        n = 1;
        while (!ack0 && n < 200) begin
            tick();
            n++;
            if (n == TA + TG + 1) check("t1 latched wdata", 16'(ad_out), 16'h0045);
        end
        check("t1 length", 16'(n), 16'(12));
        req0 = 1'b0;
        tick();
        chk1("t1 idle busy", busy, 1'b0);

        // Read on port 1; the pad carries 0x37 only on the last DATA cycle.
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'h22;
        tick();
        chk1("t2 rd addr", rd, 1'b0);
        check("t2 addr", 16'(ad_out), 16'h0022);
        n = 1;
        while (!ack1 && n < 200) begin
            ad_in = (n == 2 * TA + TG) ? 8'h37 : (8'h5A ^ 8'(n));
            tick();
            n++;
            if (n == TA + TG + 1) begin
                chk1("t2 data oe", ad_oe, 1'b0);
                chk1("t2 data rd", rd, 1'b0);
            end
        end
        check("t2 length", 16'(n), 16'(12));
        check("t2 rdata at ack", 16'(rdata), 16'h0037);
        req1 = 1'b0; ad_in = 8'hFF;
        tick();
        tick();
        check("t2 rdata held", 16'(rdata), 16'h0037);

        // Simultaneous requests straight after reset, then alternation.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h10; wdata0 = 8'h11;
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'h30;
        tick();
        check("t3 first is p0", 16'(ad_out), 16'h0010);
        wait_ack(1'b0, n);
        check("t3 p0 len", 16'(n), 16'(L - 1));
        req0 = 1'b0;
        tick();
        chk1("t3 idle between", busy, 1'b0);
        tick();
        check("t3 then p1", 16'(ad_out), 16'h0030);
        wait_ack(1'b1, n);
        check("t3 p1 len", 16'(n), 16'(L - 1));
        req1 = 1'b0;
        tick();
        req0 = 1'b1; req1 = 1'b1;
        tick();
        check("t3 alternates to p0", 16'(ad_out), 16'h0010);
        wait_ack(1'b0, n);
        req0 = 1'b0;
        wait_ack(1'b1, n);
        check("t3 p1 after p0", 16'(n), 16'(L + 1));
        req1 = 1'b0;
        tick();

        // Reset in the middle of a write DATA phase.
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h55; wdata0 = 8'h66;
        tick();
        repeat (TA + TG + 1) tick();
        chk1("t4 mid data wr", wr, 1'b0);
        #2 rst = 1'b0;
        #1;
        chk1("t4 rst cs", cs, 1'b1);
        chk1("t4 rst wr", wr, 1'b1);
        chk1("t4 rst a_d", a_d, 1'b1);
        chk1("t4 rst oe", ad_oe, 1'b0);
        chk1("t4 rst ack", ack0, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        chk1("t4 restart addr", a_d, 1'b0);
        check("t4 restart ad_out", 16'(ad_out), 16'h0055);

        // Continuous request: one busy-low cycle between transactions.
        wait_ack(1'b0, n);
        check("t5 len", 16'(n), 16'(L - 1));
        k = 0; busy_low = 0;
        while (a_d && k < 50) begin
            tick();
            k++;
            if (!busy) busy_low++;
        end
        check("t5 ack to next addr", 16'(k), 16'(2));
        check("t5 busy low cycles", 16'(busy_low), 16'(1));
        wait_ack(1'b0, n);
        check("t5 second len", 16'(n), 16'(L - 1));
        req0 = 1'b0;
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
